// File: rtl/transaction_controller_if.sv
// Handshake bundle between the user-input debouncers, the transaction
// controller and the coin-transfer datapath.
interface transaction_controller_if;
  logic       start;
  logic       next;
  logic       cancel;
  logic       done_step;
  logic [2:0] process;
  logic       load_register;
  logic       load_player;
  logic       load_amount;
  logic       load_key;
  logic       mem_write;
  logic       busy;
  logic       accepted;
  logic       rejected;
  logic [3:0] state_out;

  // master: user/datapath side; slave: the sequencing controller
  modport master (
    output start, next, cancel, done_step,
    input  process, load_register, load_player, load_amount, load_key,
           mem_write, busy, accepted, rejected, state_out
  );
  modport slave (
    input  start, next, cancel, done_step,
    output process, load_register, load_player, load_amount, load_key,
           mem_write, busy, accepted, rejected, state_out
  );
endinterface

// File: rtl/transaction_controller.sv
// Sequencing FSM for the coin-transfer datapath: snapshot, capture fields,
// verify amount and key, commit, write back, then pulse accepted/rejected.
module transaction_controller #(
  parameter int AMOUNT_WAIT = 4,
  parameter int KEY_TIMEOUT = 64
) (
  input  logic                     clock,
  input  logic                     reset,
  transaction_controller_if.slave  bus
);

  typedef enum logic [3:0] {
    IDLE       = 4'd0,
    LOAD_REG   = 4'd1,
    GET_PLAYER = 4'd2,
    GET_AMOUNT = 4'd3,
    GET_KEY    = 4'd4,
    CHK_AMOUNT = 4'd5,
    CHK_KEY    = 4'd6,
    COMMIT     = 4'd7,
    WRITE      = 4'd8,
    ACCEPT     = 4'd9,
    REJECT     = 4'd10
  } state_t;

  localparam logic [7:0] AMT_LAST = 8'(AMOUNT_WAIT - 1);
  localparam logic [7:0] KEY_LAST = 8'(KEY_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       ld_player, ld_amount, ld_key;
  logic       in_chk;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    ld_player = 1'b0;
    ld_amount = 1'b0;
    ld_key    = 1'b0;
    case (state)
      IDLE:       if (bus.start) state_nxt = LOAD_REG;
      LOAD_REG:   state_nxt = GET_PLAYER;
      // cancel has priority over next in every field-capture state
      GET_PLAYER: begin
        if (bus.cancel) state_nxt = IDLE;
        else if (bus.next) begin
          ld_player = 1'b1;
          state_nxt = GET_AMOUNT;
        end
      end
      GET_AMOUNT: begin
        if (bus.cancel) state_nxt = IDLE;
        else if (bus.next) begin
          ld_amount = 1'b1;
          state_nxt = GET_KEY;
        end
      end
      GET_KEY: begin
        if (bus.cancel) state_nxt = IDLE;
        else if (bus.next) begin
          ld_key    = 1'b1;
          state_nxt = CHK_AMOUNT;
        end
      end
      // done_step at cnt==0 still reflects the previous process code
      CHK_AMOUNT: begin
        if (cnt != 8'd0 && bus.done_step) state_nxt = CHK_KEY;
        else if (cnt == AMT_LAST)         state_nxt = REJECT;
      end
      CHK_KEY: begin
        if (cnt != 8'd0 && bus.done_step) state_nxt = COMMIT;
        else if (cnt == KEY_LAST)         state_nxt = REJECT;
      end
      COMMIT:  state_nxt = WRITE;
      WRITE:   state_nxt = ACCEPT;
      ACCEPT:  state_nxt = IDLE;
      REJECT:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // dwell counter only runs while staying in a verify state
  assign in_chk  = (state == CHK_AMOUNT) || (state == CHK_KEY);
  assign cnt_nxt = (in_chk && state_nxt == state) ? cnt + 8'd1 : 8'd0;

  always_comb begin
    case (state)
      CHK_AMOUNT: bus.process = 3'b001;
      CHK_KEY:    bus.process = 3'b010;
      COMMIT:     bus.process = 3'b011;
      default:    bus.process = 3'b000;
    endcase
  end

  assign bus.load_register = (state == LOAD_REG);
  assign bus.load_player   = ld_player;
  assign bus.load_amount   = ld_amount;
  assign bus.load_key      = ld_key;
  assign bus.mem_write     = (state == WRITE);
  assign bus.busy          = (state != IDLE);
  assign bus.accepted      = (state == ACCEPT);
  assign bus.rejected      = (state == REJECT);
  assign bus.state_out     = state;

endmodule
